// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the MIPS-subset CPU: opcode/funct constants,
// ALU operation encoding and the packed control-strobe payload.
package cpu_isa_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNC_W   = 6;
  localparam int unsigned ALU_OP_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;

  localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNC_W-1:0] FN_XOR = 6'b100110;

  // Codes 110 and 111 are reserved and never driven
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_LUI = 3'b101
  } alu_op_t;

  // Datapath control strobes for one instruction
  typedef struct packed {
    logic    reg_dst;
    logic    reg_write;
    logic    alu_src;
    logic    mem_write;
    logic    mem_read;
    logic    mem_to_reg;
    logic    branch;
    alu_op_t alu_op;
  } ctrl_t;

  // All strobes low, ALU_op=ADD: no architectural state change
  localparam ctrl_t CTRL_NOP = '{
    reg_dst: 1'b0, reg_write: 1'b0, alu_src: 1'b0, mem_write: 1'b0,
    mem_read: 1'b0, mem_to_reg: 1'b0, branch: 1'b0, alu_op: ALU_ADD
  };

endpackage

// File: rtl/control_unit_dec_if.sv
// Instruction-in / control-out bundle of the main decoder.
//   master : drives op, func, instr_valid; receives strobes and status
//   slave  : the decoder
interface control_unit_dec_if;
  import cpu_isa_pkg::*;

  logic [OP_W-1:0]     op;
  logic [FUNC_W-1:0]   func;
  logic                instr_valid;
  logic                RegDst;
  logic                RegWrite;
  logic                ALUSrc;
  logic                MemWrite;
  logic                MemRead;
  logic                MemtoReg;
  logic                Branch;
  logic [ALU_OP_W-1:0] ALU_op;
  logic                illegal;
  logic                illegal_seen;

  modport master (
    output op, func, instr_valid,
    input  RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch,
           ALU_op, illegal, illegal_seen
  );

  modport slave (
    input  op, func, instr_valid,
    output RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch,
           ALU_op, illegal, illegal_seen
  );

endinterface

// File: rtl/control_unit_dec_alu_func_dec.sv
// R-type function decoder: maps func to an ALU operation and flags whether
// func is one of the supported R-type operations.
//   func     in  6  instruction[5:0]
//   alu_op   out 3  ALU operation (ADD when func is unsupported)
//   rtype_ok out 1  func is a supported R-type function
module alu_func_dec
  import cpu_isa_pkg::*;
(
  input  logic [FUNC_W-1:0] func,
  output alu_op_t           alu_op,
  output logic              rtype_ok
);

  // Unknown or unsupported func falls into the default arm
  always_comb begin
    alu_op   = ALU_ADD;
    rtype_ok = 1'b0;
    case (func)
      FN_ADD: begin alu_op = ALU_ADD; rtype_ok = 1'b1; end
      FN_SUB: begin alu_op = ALU_SUB; rtype_ok = 1'b1; end
      FN_AND: begin alu_op = ALU_AND; rtype_ok = 1'b1; end
      FN_OR:  begin alu_op = ALU_OR;  rtype_ok = 1'b1; end
      FN_XOR: begin alu_op = ALU_XOR; rtype_ok = 1'b1; end
      default: begin
        alu_op   = ALU_ADD;
        rtype_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_unit_dec.sv
// Main instruction decoder for the single-cycle MIPS-subset CPU.
// Decodes op/func into datapath strobes and an ALU operation, flags
// unsupported instructions and keeps a sticky illegal-instruction status.
//   clk    in  1  clock for the status register (and optional output register)
//   reset  in  1  asynchronous, active-high reset
//   bus    slave  op/func/instr_valid in; strobes, ALU_op, illegal,
//                 illegal_seen out
// Build option: define CU_OUT_REG_EN to register the decode outputs and
// illegal (1-cycle latency, NOP during reset).
module control_unit_dec
  import cpu_isa_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  control_unit_dec_if.slave  bus
);

  ctrl_t   ctrl_c;
  logic    illegal_c;
  alu_op_t fn_alu_op;
  logic    fn_ok;
  ctrl_t   ctrl_o;
  logic    illegal_o;
  logic    illegal_seen_q;

  alu_func_dec u_alu_func_dec (
    .func     (bus.func),
    .alu_op   (fn_alu_op),
    .rtype_ok (fn_ok)
  );

  // Opcode decode; anything not listed (including X/Z) is a NOP + illegal
  always_comb begin
    ctrl_c    = CTRL_NOP;
    illegal_c = 1'b0;
    case (bus.op)
      OP_RTYPE: begin
        if (fn_ok) begin
          ctrl_c.reg_dst   = 1'b1;
          ctrl_c.reg_write = 1'b1;
          ctrl_c.alu_op    = fn_alu_op;
        end else begin
          illegal_c = 1'b1;
        end
      end
      OP_LW: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.alu_src    = 1'b1;
        ctrl_c.mem_read   = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.mem_write = 1'b1;
        ctrl_c.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_c.branch = 1'b1;
        ctrl_c.alu_op = ALU_SUB;
      end
      OP_LUI: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = ALU_LUI;
      end
      default: begin
        ctrl_c    = CTRL_NOP;
        illegal_c = 1'b1;
      end
    endcase
  end

`ifdef CU_OUT_REG_EN
  // Pipeline register; reset presents a harmless NOP downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_o    <= CTRL_NOP;
      illegal_o <= 1'b0;
    end else begin
      ctrl_o    <= ctrl_c;
      illegal_o <= illegal_c;
    end
  end
`else
  assign ctrl_o    = ctrl_c;
  assign illegal_o = illegal_c;
`endif

  // Sticky status samples the undelayed decode in both build variants
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_seen_q <= 1'b0;
    end else if (bus.instr_valid && illegal_c) begin
      illegal_seen_q <= 1'b1;
    end
  end

  assign bus.RegDst       = ctrl_o.reg_dst;
  assign bus.RegWrite     = ctrl_o.reg_write;
  assign bus.ALUSrc       = ctrl_o.alu_src;
  assign bus.MemWrite     = ctrl_o.mem_write;
  assign bus.MemRead      = ctrl_o.mem_read;
  assign bus.MemtoReg     = ctrl_o.mem_to_reg;
  assign bus.Branch       = ctrl_o.branch;
  assign bus.ALU_op       = ctrl_o.alu_op;
  assign bus.illegal      = illegal_o;
  assign bus.illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_control_unit_dec.sv
// Self-checking bench for control_unit_dec: directed vector table,
// reset/latency sequences and randomized stimulus against a table-lookup
// reference model. Output word layout:
// {RegDst,RegWrite,ALUSrc,MemWrite,MemRead,MemtoReg,Branch,ALU_op[2:0],illegal}
module tb_control_unit_dec;

  logic clk = 1'b0;
  logic reset;

  control_unit_dec_if bus ();

  control_unit_dec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] dut_out;
  assign dut_out = {bus.RegDst, bus.RegWrite, bus.ALUSrc, bus.MemWrite,
                    bus.MemRead, bus.MemtoReg, bus.Branch, bus.ALU_op,
                    bus.illegal};

  localparam logic [10:0] NOP_ILL = 11'b0000000_000_1;
  localparam logic [10:0] NOP_RST = 11'b0000000_000_0;

  // Reference ISA: one row per supported instruction
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  func;
    logic        uses_func;
    logic [10:0] out;
  } isa_row_t;

  isa_row_t isa [9];

  initial begin
    isa[0] = '{6'b000000, 6'b100000, 1'b1, 11'b1100000_000_0};
    isa[1] = '{6'b000000, 6'b100010, 1'b1, 11'b1100000_001_0};
    isa[2] = '{6'b000000, 6'b100100, 1'b1, 11'b1100000_010_0};
    isa[3] = '{6'b000000, 6'b100101, 1'b1, 11'b1100000_011_0};
    isa[4] = '{6'b000000, 6'b100110, 1'b1, 11'b1100000_100_0};
    isa[5] = '{6'b100011, 6'b000000, 1'b0, 11'b0110110_000_0};
    isa[6] = '{6'b101011, 6'b000000, 1'b0, 11'b0011000_000_0};
    isa[7] = '{6'b000100, 6'b000000, 1'b0, 11'b0000001_001_0};
    isa[8] = '{6'b001111, 6'b000000, 1'b0, 11'b0110000_101_0};
  end

  function automatic logic [10:0] ref_decode(logic [5:0] op, logic [5:0] func);
    for (int i = 0; i < 9; i++) begin
      if (isa[i].op == op && (!isa[i].uses_func || isa[i].func == func))
        return isa[i].out;
    end
    return NOP_ILL;
  endfunction

  function automatic logic ref_illegal(logic [5:0] op, logic [5:0] func);
    logic [10:0] r;
    r = ref_decode(op, func);
    return r[0];
  endfunction

  // Sticky-flag model
  logic seen_m;
  always @(posedge clk or posedge reset) begin
    if (reset) seen_m <= 1'b0;
    else if (bus.instr_valid && ref_illegal(bus.op, bus.func)) seen_m <= 1'b1;
  end

  task automatic check(string name, logic [10:0] act, logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(logic [5:0] op, logic [5:0] func, logic iv);
    @(negedge clk);
    bus.op          = op;
    bus.func        = func;
    bus.instr_valid = iv;
  endtask

  // Checks outputs (zero latency or after one edge) and the sticky flag
  task automatic check_vec(string name, logic [10:0] exp);
`ifndef CU_OUT_REG_EN
    #1 check({name, "/comb"}, dut_out, exp);
`endif
    @(posedge clk);
    #1;
    check(name, dut_out, exp);
    check({name, "/seen"}, 11'(bus.illegal_seen), 11'(seen_m));
  endtask

  task automatic reset_pulse_midcycle(string name);
    reset = 1'b1;
    #1;
    check({name, "/seen_async_clear"}, 11'(bus.illegal_seen), 11'd0);
`ifdef CU_OUT_REG_EN
    check({name, "/out_nop"}, dut_out, NOP_RST);
`endif
    #1 reset = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        iv;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(string name, logic [5:0] op, logic [5:0] func,
                         logic iv, logic [10:0] exp);
    vec_t v;
    v = '{name, op, func, iv, exp};
    vecs.push_back(v);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  rop, rfunc;
    logic        riv;
    logic [10:0] lui_exp;
    logic [5:0]  legal_ops [4];
    logic [5:0]  rtype_fn  [5];

    legal_ops = '{6'b100011, 6'b101011, 6'b000100, 6'b001111};
    rtype_fn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110};

    add_vec("add",      6'b000000, 6'b100000, 1'b1, 11'b1100000_000_0);
    add_vec("sub",      6'b000000, 6'b100010, 1'b1, 11'b1100000_001_0);
    add_vec("and",      6'b000000, 6'b100100, 1'b1, 11'b1100000_010_0);
    add_vec("or",       6'b000000, 6'b100101, 1'b1, 11'b1100000_011_0);
    add_vec("xor",      6'b000000, 6'b100110, 1'b1, 11'b1100000_100_0);
    add_vec("lw",       6'b100011, 6'b100110, 1'b1, 11'b0110110_000_0);
    add_vec("sw",       6'b101011, 6'b100110, 1'b1, 11'b0011000_000_0);
    add_vec("beq",      6'b000100, 6'b100110, 1'b1, 11'b0000001_001_0);
    add_vec("lui",      6'b001111, 6'b100110, 1'b1, 11'b0110000_101_0);
    add_vec("ill_f0",   6'b000000, 6'b000000, 1'b0, NOP_ILL);
    add_vec("ill_f21",  6'b000000, 6'b100001, 1'b0, NOP_ILL);
    add_vec("ill_op3f", 6'b111111, 6'b100000, 1'b0, NOP_ILL);
    add_vec("ill_op02", 6'b000010, 6'b000000, 1'b0, NOP_ILL);
    add_vec("ill_f0_v", 6'b000000, 6'b000000, 1'b1, NOP_ILL);
    add_vec("add_post", 6'b000000, 6'b100000, 1'b1, 11'b1100000_000_0);

    // Reset state: sticky flag clear; decode unaffected unless registered
    reset           = 1'b1;
    bus.op          = 6'b101011;
    bus.func        = 6'b000000;
    bus.instr_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst/seen", 11'(bus.illegal_seen), 11'd0);
`ifdef CU_OUT_REG_EN
    check("rst/out", dut_out, NOP_RST);
`else
    check("rst/out", dut_out, 11'b0011000_000_0);
`endif
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].func, vecs[i].iv);
      check_vec(vecs[i].name, vecs[i].exp);
    end
    check("seq/seen_set", 11'(bus.illegal_seen), 11'd1);

    // Asynchronous clear between clock edges, then reset beats a set
    #2;
    reset_pulse_midcycle("midrst");
    apply(6'b000000, 6'b000000, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wins/seen", 11'(bus.illegal_seen), 11'd0);
    @(negedge clk);
    reset = 1'b0;
    apply(6'b000000, 6'b100000, 1'b0);
    check_vec("post_rst_add", 11'b1100000_000_0);

    // Output latency
    apply(6'b001111, 6'b000000, 1'b1);
    lui_exp = 11'b0110000_101_0;
    check_vec("lat_lui", lui_exp);
    apply(6'b101011, 6'b000000, 1'b1);
`ifdef CU_OUT_REG_EN
    #1 check("lat_hold", dut_out, lui_exp);
`endif
    check_vec("lat_sw", 11'b0011000_000_0);

    // func must be ignored for non-R-type ops
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 6; j++) begin
        rfunc = 6'($urandom);
        apply(legal_ops[k], rfunc, 1'b1);
        check_vec($sformatf("fsweep_op%b_f%b", legal_ops[k], rfunc),
                  ref_decode(legal_ops[k], 6'b000000));
      end
    end

    // Randomized stimulus against the reference model
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: rop = 6'b000000;
        1: rop = legal_ops[$urandom_range(0, 3)];
        default: rop = 6'($urandom);
      endcase
      rfunc = ($urandom_range(0, 1) == 0) ? rtype_fn[$urandom_range(0, 4)]
                                          : 6'($urandom);
      riv = ($urandom_range(0, 3) == 0);
      apply(rop, rfunc, riv);
      check_vec($sformatf("rnd%0d_op%b_f%b", n, rop, rfunc), ref_decode(rop, rfunc));
      if ($urandom_range(0, 19) == 0) begin
        #2;
        reset_pulse_midcycle($sformatf("rnd%0d_rst", n));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit_dec.md
Name: control_unit_dec

Overview:
- Main decoder for the single-cycle MIPS-subset CPU.
- Maps instruction opcode `op` and R-type function field `func` to datapath control strobes and a 3-bit ALU operation code.
- Sits between the instruction memory output and the register file, ALU, data memory and PC-select logic.
- Decode is combinational; a small registered status block flags unsupported instructions.

Parameters:
- ALU_OP_W, 3, width of `ALU_op` (fixed; other values unsupported).

Ports:
- clk  in  1  system clock; only the status register and the optional output register use it.
- reset  in  1  asynchronous, active-high reset.
- op  in  6  instruction[31:26].
- func  in  6  instruction[5:0]; used only when op=000000.
- instr_valid  in  1  qualifies the illegal-instruction sticky update.
- RegDst  out  1  1 = write rd, 0 = write rt.
- RegWrite  out  1  register file write enable.
- ALUSrc  out  1  1 = ALU operand B is the extended immediate.
- MemWrite  out  1  data memory write enable.
- MemRead  out  1  data memory read enable.
- MemtoReg  out  1  1 = writeback data comes from memory.
- Branch  out  1  beq branch request; PC logic ANDs it with ALU zero.
- ALU_op  out  3  ALU operation.
- illegal  out  1  current op/func is unsupported.
- illegal_seen  out  1  sticky flag: an unsupported instruction was decoded.

Behaviour:
- ALU_op encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LUI (imm<<16). Codes 110 and 111 are never driven.
- Decode table, with outputs listed as RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch, ALU_op:
  - op 000000, func 100000 (add): 1,1,0,0,0,0,0, 000
  - op 000000, func 100010 (sub): 1,1,0,0,0,0,0, 001
  - op 000000, func 100100 (and): 1,1,0,0,0,0,0, 010
  - op 000000, func 100101 (or): 1,1,0,0,0,0,0, 011
  - op 000000, func 100110 (xor): 1,1,0,0,0,0,0, 100
  - op 100011 (lw): 0,1,1,0,1,1,0, 000
  - op 101011 (sw): 0,0,1,1,0,0,0, 000
  - op 000100 (beq): 0,0,0,0,0,0,1, 001
  - op 001111 (lui): 0,1,1,0,0,0,0, 101
- Unsupported instruction: any other op, or op=000000 with any other func (including func 000000). All strobes are 0, ALU_op=000, and `illegal`=1. This guarantees no architectural state change (NOP).
- `func` is ignored for every non-R-type op; sweeping it must not change the outputs.
- Decode outputs and `illegal` are purely combinational with zero latency and are unaffected by `reset`.
- `illegal_seen`:
  - Set on the rising edge of `clk` when `instr_valid`=1 and `illegal`=1.
  - Holds until reset.
  - Asynchronously cleared to 0 while `reset`=1; reset wins over a simultaneous set.
- No X propagation: if any bit of op/func is X/Z, the block drives the unsupported-instruction outputs.

Optional Feature:
- Macro: CU_OUT_REG_EN.
- Defined:
  - All eight decode outputs and `illegal` are registered on posedge `clk`, giving 1-cycle latency for pipelined reuse.
  - Asynchronous reset drives them to the NOP encoding: all 0, ALU_op=000, illegal=0.
  - `illegal_seen` samples the combinational `illegal`, so its timing is unchanged.
- Undefined: the combinational behaviour above.

Decomposition:
- Shared package `cpu_isa_pkg` holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_LUI;
  - funct constants FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR;
  - an `alu_op_t` enum (3-bit) with the encodings above.
- One sub-module, `alu_func_dec`: maps func to ALU_op and an R-type-valid bit.
- The top module holds the main opcode decode, the sticky status register and the optional output register.

Test Plan:
- Sweep the five R-type funcs (100000, 100010, 100100, 100101, 100110) with op=000000 → RegDst=1, RegWrite=1, other strobes 0, ALU_op=000, 001, 010, 011, 100 respectively, illegal=0.
- op=100011 then 101011, func=100110 → lw gives 0,1,1,0,1,1,0,000; sw gives 0,0,1,1,0,0,0,000.
- op=000100 then 001111, func=100110 → beq gives Branch=1, ALU_op=001, RegWrite=0; lui gives RegWrite=1, ALUSrc=1, ALU_op=101.
- op=000000, func=000000 with instr_valid=1 → all strobes 0, illegal=1; after the next posedge `illegal_seen`=1.
- Same illegal instruction with instr_valid=0 → `illegal_seen` stays 0.
- Assert `reset` mid-cycle while `illegal_seen`=1 → it clears immediately without waiting for a clock. With CU_OUT_REG_EN, outputs follow the inputs one cycle later and read as NOP during reset.
